// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: runs one register-to-register instruction at a time
// through the shared 16x4 register file and the single registered 4-bit ALU.
module alu_seq_ctrl #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic [2:0]    opcode_i,
    input  logic [AW-1:0] rd_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [DW-1:0] imm_i,
    output logic [AW-1:0] rf_rr1_o,
    output logic [AW-1:0] rf_rr2_o,
    output logic [AW-1:0] rf_wr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic          rf_wenable_o,
    input  logic [DW-1:0] rf_rdata1_i,
    input  logic [DW-1:0] rf_rdata2_i,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [1:0]    alu_select_o,
    input  logic [DW-1:0] alu_res_i,
    input  logic          alu_cf_i,
    input  logic          alu_zf_i,
    input  logic          alu_sf_i,
    output logic [DW-1:0] res_o,
    output logic          cf_o,
    output logic          zf_o,
    output logic          sf_o,
    output logic          invalid_o,
    output logic          done_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_EXE,
        S_WB
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    opcode_q, opcode_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] rr1_q, rr1_d;
    logic [AW-1:0] rr2_q, rr2_d;
    logic [AW-1:0] wr_q, wr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] res_q, res_d;
    logic          cf_q, cf_d;
    logic          zf_q, zf_d;
    logic          sf_q, sf_d;
    logic          inv_q, inv_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            rr1_q    <= '0;
            rr2_q    <= '0;
            wr_q     <= '0;
            wen_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            res_q    <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            inv_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            rr1_q    <= rr1_d;
            rr2_q    <= rr2_d;
            wr_q     <= wr_d;
            wen_q    <= wen_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            res_q    <= res_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        rr1_d    = rr1_q;
        rr2_d    = rr2_q;
        wr_d     = wr_q;
        wen_d    = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        res_d    = res_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        inv_d    = inv_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid_i && ready_q) begin
                    opcode_d = opcode_i;
                    rd_d     = rd_i;
                    imm_d    = imm_i;
                    case (opcode_i)
                        OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                            rr1_d   = rs1_i;
                            rr2_d   = rs2_i;
                            state_d = S_RD;
                        end
                        OP_LDI: begin
                            wen_d   = 1'b1;
                            wr_d    = rd_i;
                            state_d = S_WB;
                        end
                        default: begin
                            // illegal opcode: report only, datapath untouched
                            inv_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_RD: begin
                case (opcode_q)
                    OP_AND:  sel_d = 2'b10;
                    OP_OR:   sel_d = 2'b11;
                    OP_ADD:  sel_d = 2'b00;
                    default: sel_d = 2'b01;
                endcase
                state_d = S_LAT;
            end
            S_LAT: begin
                a_d     = rf_rdata1_i;
                b_d     = rf_rdata2_i;
                state_d = S_EXE;
            end
            S_EXE: begin
                wen_d   = 1'b1;
                wr_d    = rd_q;
                state_d = S_WB;
            end
            S_WB: begin
                if (opcode_q == OP_LDI) begin
                    res_d = imm_q;
                end else begin
                    res_d = alu_res_i;
                    cf_d  = alu_cf_i;
                    zf_d  = alu_zf_i;
                    sf_d  = alu_sf_i;
                end
                inv_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // The ALU result only becomes valid at the start of WB, so the write data
    // is selected from the already-registered ALU output during that cycle.
    assign rf_wdata_o    = wen_q ? ((opcode_q == OP_LDI) ? imm_q : alu_res_i) : '0;
    assign rf_wenable_o  = wen_q;
    assign rf_wr_o       = wr_q;
    assign rf_rr1_o      = rr1_q;
    assign rf_rr2_o      = rr2_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_select_o  = sel_q;
    assign res_o         = res_q;
    assign cf_o          = cf_q;
    assign zf_o          = zf_q;
    assign sf_o          = sf_q;
    assign invalid_o     = inv_q;
    assign done_o        = done_q;
    assign instr_ready_o = ready_q;

endmodule
